// File: rtl/soup_pkg.sv
// soup_pkg: shared definitions for the life-soup host link.
//   - ASCII character constants used on the serial protocol
//   - transmit / receive FSM state encodings
//   - payload widths (command payload, report payload as a function of INIT)
package soup_pkg;

   localparam logic [7:0] CH_R = 8'h52;
   localparam logic [7:0] CH_A = 8'h41;
   localparam logic [7:0] CH_M = 8'h4d;
   localparam logic [7:0] CH_H = 8'h48;
   localparam logic [7:0] CH_L = 8'h4c;
   localparam logic [7:0] CH_0 = 8'h30;
   localparam logic [7:0] CH_1 = 8'h31;

   // Command payload: 34 ASCII bits after the command character.
   localparam int CMD_W = 34;

   // Report payload: one bit per cell plus a 32-bit trailer.
   function automatic int rsp_width(input int init);
      return init * init + 32;
   endfunction

   typedef enum logic [1:0] {T_IDLE, T_CHAR, T_BITS, T_NEXT} tx_state_t;
   typedef enum logic [1:0] {R_HUNT, R_BITS, R_DISPATCH} rx_state_t;

endpackage

// File: rtl/soup_host_byte_rx.sv
// soup_host_byte_rx: start/sample/stop deserialiser for one 8N1 character.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   rx             serial input, already synchronous to clk
//   byte_valid     one-cycle pulse (during R_DISPATCH) with a good character
//   byte_data      received character, valid while byte_valid is high
//   frame_err      one-cycle pulse when the stop bit is sampled low
// Offsets count from the first cycle rx is seen low (offset 0). The start
// bit is rechecked at PERIOD, data bit i at 2*PERIOD*(i+1)+PERIOD and the
// stop bit at 19*PERIOD, i.e. every sample point is PERIOD + 2*PERIOD*k.
module soup_host_byte_rx
   import soup_pkg::*;
#(
   parameter int PERIOD = 434
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int CW = $clog2(22 * PERIOD + 1);

   rx_state_t       state_reg;
   logic [CW-1:0]   cnt_reg;
   logic [CW-1:0]   samp_reg;   // offset of the next sample point
   logic [3:0]      bit_reg;    // 0 = start, 1..8 = data, 9 = stop
   logic [7:0]      shift_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= R_HUNT;
         cnt_reg    <= '0;
         samp_reg   <= '0;
         bit_reg    <= '0;
         shift_reg  <= '0;
         byte_data  <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state_reg)
            R_HUNT: begin
               if (!rx) begin
                  state_reg <= R_BITS;
                  cnt_reg   <= CW'(1);
                  samp_reg  <= CW'(PERIOD);
                  bit_reg   <= '0;
               end
            end
            R_BITS: begin
               cnt_reg <= cnt_reg + CW'(1);
               if (cnt_reg == samp_reg) begin
                  samp_reg <= samp_reg + CW'(2 * PERIOD);
                  bit_reg  <= bit_reg + 4'd1;
                  if (bit_reg == 4'd0) begin
                     // Start bit gone high again: treat as a glitch.
                     if (rx) state_reg <= R_HUNT;
                  end else if (bit_reg == 4'd9) begin
                     if (rx) begin
                        state_reg  <= R_DISPATCH;
                        byte_valid <= 1'b1;
                        byte_data  <= shift_reg;
                     end else begin
                        state_reg <= R_HUNT;
                        frame_err <= 1'b1;
                     end
                  end else begin
                     shift_reg <= {rx, shift_reg[7:1]};
                  end
               end
            end
            R_DISPATCH: state_reg <= R_HUNT;
            default:    state_reg <= R_HUNT;
         endcase
      end
   end

endmodule

// File: rtl/soup_host_link.sv
// soup_host_link: host-side endpoint of the life-soup serial protocol.
// Transmit: serialises a command character followed by 34 ASCII '0'/'1'
// characters (cmd_data bit 0 first) onto tx. Receive: parses 'H' reports
// and 'L' reports carrying NI+32 ASCII bits, NI = INIT*INIT.
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake; cmd_ready high when idle
//   cmd_char, cmd_data      command character and 34-bit payload
//   tx                      serial output, idles high
//   rx                      serial input from the engine
//   rsp_valid               one-cycle pulse when a report completes
//   rsp_halt, rsp_life      kind of the last completed report
//   rsp_data                payload of the last 'L' report
//   err                     one-cycle pulse on framing or protocol error
// Build option: define SOUP_HOST_RX_SYNC_EN to pass rx through a two-flop
// synchroniser (adds 2 clocks of receive latency).
module soup_host_link
   import soup_pkg::*;
#(
   parameter int INIT   = 20,
   parameter int PERIOD = 434,
   parameter int GAP    = 4
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [7:0]             cmd_char,
   input  logic [33:0]            cmd_data,
   output logic                   tx,
   input  logic                   rx,
   output logic                   rsp_valid,
   output logic                   rsp_halt,
   output logic                   rsp_life,
   output logic [INIT*INIT+31:0]  rsp_data,
   output logic                   err
);

   localparam int RW  = rsp_width(INIT);
   localparam int TCW = $clog2(20 * PERIOD + GAP + 1);
   localparam int DCW = $clog2(INIT * INIT + 33);
   localparam logic [TCW-1:0] BIT_LAST  = TCW'(2 * PERIOD - 1);
   localparam logic [TCW-1:0] STOP_LAST = TCW'(2 * PERIOD + GAP - 1);
   localparam logic [5:0]     LAST_CHAR = 6'(CMD_W);
   localparam logic [DCW-1:0] LAST_IDX  = DCW'(RW - 1);

   // ---------------------------------------------------------------- rx input
   logic rx_s;
`ifdef SOUP_HOST_RX_SYNC_EN
   logic [1:0] rx_sync_reg;
   always_ff @(posedge clk) begin
      if (reset) rx_sync_reg <= 2'b11;
      else       rx_sync_reg <= {rx_sync_reg[0], rx};
   end
   assign rx_s = rx_sync_reg[1];
`else
   assign rx_s = rx;
`endif

   // ---------------------------------------------------------------- transmit
   tx_state_t           tx_state_reg;
   logic [TCW-1:0]      tx_cnt_reg;
   logic [3:0]          tx_bit_reg;
   logic [5:0]          tx_char_reg;   // 0 = command char, k+1 = data bit k
   logic [7:0]          tx_shift_reg;
   logic [CMD_W-1:0]    tx_data_reg;
   logic                tx_reg;

   assign cmd_ready = (tx_state_reg == T_IDLE);
   assign tx        = tx_reg;

   // The next character's start bit is driven on the same edge that ends
   // the previous stop bit, so characters follow back to back with no
   // extra cycle spent in T_NEXT bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_reg <= T_IDLE;
         tx_cnt_reg   <= '0;
         tx_bit_reg   <= '0;
         tx_char_reg  <= '0;
         tx_shift_reg <= '0;
         tx_data_reg  <= '0;
         tx_reg       <= 1'b1;
      end else begin
         case (tx_state_reg)
            T_IDLE: begin
               tx_reg <= 1'b1;
               if (cmd_valid) begin
                  tx_data_reg  <= cmd_data;
                  tx_shift_reg <= cmd_char;
                  tx_char_reg  <= '0;
                  tx_cnt_reg   <= '0;
                  tx_reg       <= 1'b0;
                  tx_state_reg <= T_CHAR;
               end
            end
            T_CHAR: begin
               if (tx_cnt_reg == BIT_LAST) begin
                  tx_cnt_reg   <= '0;
                  tx_bit_reg   <= '0;
                  tx_reg       <= tx_shift_reg[0];
                  tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                  tx_state_reg <= T_BITS;
               end else begin
                  tx_cnt_reg <= tx_cnt_reg + TCW'(1);
               end
            end
            T_BITS: begin
               if (tx_cnt_reg == BIT_LAST) begin
                  tx_cnt_reg <= '0;
                  if (tx_bit_reg == 4'd7) begin
                     tx_reg       <= 1'b1;
                     tx_state_reg <= T_NEXT;
                  end else begin
                     tx_bit_reg   <= tx_bit_reg + 4'd1;
                     tx_reg       <= tx_shift_reg[0];
                     tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                  end
               end else begin
                  tx_cnt_reg <= tx_cnt_reg + TCW'(1);
               end
            end
            T_NEXT: begin
               if (tx_cnt_reg == STOP_LAST) begin
                  tx_cnt_reg <= '0;
                  if (tx_char_reg == LAST_CHAR) begin
                     tx_state_reg <= T_IDLE;
                  end else begin
                     tx_shift_reg <= tx_data_reg[tx_char_reg] ? CH_1 : CH_0;
                     tx_char_reg  <= tx_char_reg + 6'd1;
                     tx_reg       <= 1'b0;
                     tx_state_reg <= T_CHAR;
                  end
               end else begin
                  tx_cnt_reg <= tx_cnt_reg + TCW'(1);
               end
            end
            default: tx_state_reg <= T_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- receive
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       frame_err;

   soup_host_byte_rx #(
      .PERIOD (PERIOD)
   ) u_byte_rx (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx_s),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_err  (frame_err)
   );

   logic [RW-1:0]  cap_reg;
   logic [RW-1:0]  cap_next;
   logic [DCW-1:0] idx_reg;
   logic           expect_data_reg;

   // Capture buffer with the current character's bit merged in, so the
   // final character lands in rsp_data on the same edge it is written.
   always_comb begin
      cap_next          = cap_reg;
      cap_next[idx_reg] = byte_data[0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cap_reg         <= '0;
         idx_reg         <= '0;
         expect_data_reg <= 1'b0;
         rsp_valid       <= 1'b0;
         rsp_halt        <= 1'b0;
         rsp_life        <= 1'b0;
         rsp_data        <= '0;
         err             <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         err       <= 1'b0;
         if (frame_err) begin
            err <= 1'b1;
         end else if (byte_valid) begin
            if (!expect_data_reg) begin
               if (byte_data == CH_H) begin
                  rsp_halt  <= 1'b1;
                  rsp_life  <= 1'b0;
                  rsp_valid <= 1'b1;
               end else if (byte_data == CH_L) begin
                  expect_data_reg <= 1'b1;
                  idx_reg         <= '0;
               end else begin
                  err <= 1'b1;
               end
            end else if (byte_data == CH_0 || byte_data == CH_1) begin
               cap_reg <= cap_next;
               if (idx_reg == LAST_IDX) begin
                  rsp_halt        <= 1'b0;
                  rsp_life        <= 1'b1;
                  rsp_data        <= cap_next;
                  rsp_valid       <= 1'b1;
                  expect_data_reg <= 1'b0;
               end else begin
                  idx_reg <= idx_reg + DCW'(1);
               end
            end else begin
               err             <= 1'b1;
               expect_data_reg <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_soup_host_link.sv
// Directed bench for soup_host_link with INIT=2, PERIOD=4, GAP=4.
module tb_soup_host_link;

   localparam int INIT   = 2;
   localparam int PERIOD = 4;
   localparam int GAP    = 4;
   localparam int RW     = 36;
`ifdef SOUP_HOST_RX_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic [7:0]    cmd_char = 8'h00;
   logic [33:0]   cmd_data = '0;
   logic          rx = 1'b1;
   logic          cmd_ready;
   logic          tx;
   logic          rsp_valid;
   logic          rsp_halt;
   logic          rsp_life;
   logic [RW-1:0] rsp_data;
   logic          err;

   soup_host_link #(
      .INIT   (INIT),
      .PERIOD (PERIOD),
      .GAP    (GAP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_char  (cmd_char),
      .cmd_data  (cmd_data),
      .tx        (tx),
      .rx        (rx),
      .rsp_valid (rsp_valid),
      .rsp_halt  (rsp_halt),
      .rsp_life  (rsp_life),
      .rsp_data  (rsp_data),
      .err       (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: counts rsp_valid / err pulses and notes when the last
   // rsp_valid was seen.
   int vcnt = 0;
   int ecnt = 0;
   int last_v = 0;
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         vcnt++;
         last_v = cyc;
      end
      if (err === 1'b1) ecnt++;
   end

   int errors = 0;
   int checks = 0;
   int start_cyc = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one 8N1 character on rx (8 clocks per bit), then 4 idle clocks.
   // Stops early after 'limit' clocks.
   task automatic send_char(input logic [7:0] ch, input logic stop_lvl, input int limit);
      int n;
      n = 0;
      for (int s = 0; s < 10; s++) begin
         for (int c = 0; c < 2 * PERIOD; c++) begin
            if (n < limit) begin
               if (s == 0 && c == 0) start_cyc = cyc;
               rx = (s == 0) ? 1'b0 : ((s == 9) ? stop_lvl : ch[s-1]);
               tick();
               n++;
            end
         end
      end
      if (n < limit) begin
         rx = 1'b1;
         repeat (4) tick();
      end
   endtask

   logic [83:0] obs_trace;
   logic [83:0] exp_trace;
   logic [7:0]  ch;
   logic [35:0] lpay;
   int          ready_low;
   int          vb;
   int          eb;

   initial begin
      // ---------------- reset
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_tx", tx, 1'b1);
      chk("rst_ready", cmd_ready, 1'b1);
      chk("rst_rsp", {rsp_valid, rsp_halt, rsp_life, err}, 4'b0000);
      chk("rst_data", rsp_data, 36'h0);
      tick();
      chk("idle_tx", {tx, cmd_ready}, 2'b11);

      // ---------------- command 'R', data 1
      cmd_valid = 1'b1;
      cmd_char  = 8'h52;
      cmd_data  = 34'h1;
      chk("hs_ready", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
      cmd_char  = 8'h00;
      cmd_data  = '1;          // must not affect the latched command
      ready_low = 0;
      for (int j = 0; j < 35; j++) begin
         ch = (j == 0) ? 8'h52 : ((j == 1) ? 8'h31 : 8'h30);
         obs_trace = '0;
         exp_trace = '0;
         for (int t = 0; t < 84; t++) begin
            obs_trace[t] = tx;
            if (cmd_ready === 1'b0) ready_low++;
            exp_trace[t] = (t < 8) ? 1'b0 : ((t < 72) ? ch[t/8 - 1] : 1'b1);
            tick();
         end
         chk($sformatf("tx_char%0d", j), obs_trace, exp_trace);
      end
      chk("ready_low_cycles", ready_low, 35 * 84);
      chk("ready_back", {cmd_ready, tx}, 2'b11);

      // ---------------- 'H' report
      vb = vcnt; eb = ecnt;
      send_char(8'h48, 1'b1, 1000);
      chk("h_valid_cnt", vcnt - vb, 1);
      chk("h_kind", {rsp_halt, rsp_life}, 2'b10);
      chk("h_latency", last_v - start_cyc, 78 + SL);
      chk("h_err", ecnt - eb, 0);

      // ---------------- 'L' report
      vb = vcnt; eb = ecnt;
      lpay = 36'h9_0000_0001;
      send_char(8'h4c, 1'b1, 1000);
      for (int k = 0; k < 36; k++) send_char(lpay[k] ? 8'h31 : 8'h30, 1'b1, 1000);
      chk("l_valid_cnt", vcnt - vb, 1);
      chk("l_kind", {rsp_halt, rsp_life}, 2'b01);
      chk("l_data", rsp_data, 36'h9_0000_0001);
      chk("l_err", ecnt - eb, 0);

      // ---------------- errors then a good 'H'
      vb = vcnt; eb = ecnt;
      send_char(8'h58, 1'b1, 1000);
      chk("bad_lead_err", ecnt - eb, 1);
      send_char(8'h48, 1'b0, 1000);
      chk("frame_err", ecnt - eb, 2);
      chk("err_no_valid", vcnt - vb, 0);
      send_char(8'h48, 1'b1, 1000);
      chk("after_err_valid", vcnt - vb, 1);
      chk("after_err_err", ecnt - eb, 2);
      chk("after_err_kind", {rsp_halt, rsp_life}, 2'b10);
      chk("h_keeps_data", rsp_data, 36'h9_0000_0001);

      // ---------------- reset during command character 10
      cmd_valid = 1'b1;
      cmd_char  = 8'h41;
      cmd_data  = 34'h2_AAAA_AAAA;
      tick();
      cmd_valid = 1'b0;
      repeat (84 * 10 + 3) tick();
      chk("c10_start_bit", {tx, cmd_ready}, 2'b00);
      reset = 1'b1;
      tick();
      chk("c10_rst_tx", {tx, cmd_ready}, 2'b11);
      chk("c10_rst_rsp", {rsp_halt, rsp_life, rsp_data}, 38'h0);
      reset = 1'b0;
      tick();

      // ---------------- reset during report data character 20
      vb = vcnt; eb = ecnt;
      send_char(8'h4c, 1'b1, 1000);
      for (int k = 0; k < 20; k++) send_char(8'h31, 1'b1, 1000);
      send_char(8'h30, 1'b1, 30);
      reset = 1'b1;
      tick();
      chk("d20_rst_tx", tx, 1'b1);
      reset = 1'b0;
      rx    = 1'b1;
      repeat (20) tick();
      chk("d20_no_valid", vcnt - vb, 0);
      chk("d20_no_err", ecnt - eb, 0);
      chk("d20_outputs", {rsp_halt, rsp_life, rsp_data}, 38'h0);
      send_char(8'h48, 1'b1, 1000);
      chk("d20_h_valid", vcnt - vb, 1);
      chk("d20_h_kind", {rsp_halt, rsp_life}, 2'b10);
      chk("d20_h_err", ecnt - eb, 0);
      chk("d20_h_data", rsp_data, 36'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
